// File: rtl/addsub_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
//   - FSM state encoding (IDLE, RUN, DRAIN)
//   - operation codes (OP_ADD, OP_SUB)
//   - default datapath width
//   - packed NZCV flag bundle and the signed-overflow helper
package addsub_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Signed overflow from the sign bits of the effective operands x, y
  // (already swapped for reverse operations) and of the result s.
  function automatic logic calc_v(input logic op, input logic x_msb,
                                  input logic y_msb, input logic s_msb);
    if (op == OP_ADD) return (x_msb == y_msb) && (s_msb != x_msb);
    else              return (x_msb != y_msb) && (s_msb != x_msb);
  endfunction

endpackage

// File: rtl/addsub_mp_sequencer_adder.sv
// ADD_ADCS_SUBS_RSBS: one-word adder / subtractor with carry in and out.
//   a, b   in   WIDTH  operand words
//   c_in   in   1      carry in (1 for a plain subtract: x + ~y + 1)
//   op     in   1      OP_ADD / OP_SUB
//   rev    in   1      swap operands (b op a)
//   s      out  WIDTH  result word
//   c_out  out  1      carry out; NOT borrow for subtract
module ADD_ADCS_SUBS_RSBS
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op,
  input  logic             rev,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH:0]   w_sum;

  assign w_x   = rev ? b : a;
  assign w_y   = rev ? a : b;
  // One extra bit on each term so the top bit of the sum is the carry out.
  assign w_sum = {1'b0, w_x} + {1'b0, (op == OP_SUB) ? ~w_y : w_y}
               + {{WIDTH{1'b0}}, c_in};
  assign s     = w_sum[WIDTH-1:0];
  assign c_out = w_sum[WIDTH];

endmodule

// File: rtl/addsub_mp_sequencer.sv
// addsub_mp_sequencer: streams operand word pairs LSW-first through one
// ADD_ADCS_SUBS_RSBS instance, chaining carry across words, and produces one
// result word per pair plus final NZCV flags.
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_op, cmd_rev               add/sub, swapped operands
//   cmd_use_c, cmd_c              external word-0 carry-in select / value
//   cmd_nwords                    word count minus one
//   in_valid/in_ready, in_a/in_b  operand pair stream
//   abort                         synchronous abort of the running operation
//   out_valid/out_ready, out_s    result word stream, out_last on MS word
//   flags_valid, flag_n/z/c/v     flag pulse after final word, held flags
//   busy                          high in RUN and DRAIN
module addsub_mp_sequencer
  import addsub_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MAX_WORDS = 8,
  parameter int CNT_W     = $clog2(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic             cmd_rev,
  input  logic             cmd_use_c,
  input  logic             cmd_c,
  input  logic [CNT_W-1:0] cmd_nwords,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_last,
  output logic             flags_valid,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy
);

  logic [1:0]       r_state;
  logic             r_op;
  logic             r_rev;
  logic [CNT_W-1:0] r_nwords;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_zero_acc;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_s;
  logic             r_out_last;
  logic             r_flags_valid;
  flags_t           r_flags;
  // Flags of the last word wait here until that word is accepted, so an
  // abort while draining leaves the visible flags untouched.
  flags_t           r_pend;

  logic             w_in_ready;
  logic             w_pair_acc;
  logic             w_out_acc;
  logic             w_last_pair;
  logic [WIDTH-1:0] w_s;
  logic             w_c_out;
  logic             w_x_msb;
  logic             w_y_msb;
  logic             w_zero_next;

  ADD_ADCS_SUBS_RSBS #(.WIDTH(WIDTH)) u_adder (
    .a     (in_a),
    .b     (in_b),
    .c_in  (r_carry),
    .op    (r_op),
    .rev   (r_rev),
    .s     (w_s),
    .c_out (w_c_out)
  );

  // A new pair may enter only when the single output slot is free or
  // being emptied this cycle.
  assign w_in_ready  = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_pair_acc  = in_valid && w_in_ready;
  assign w_out_acc   = r_out_valid && out_ready;
  assign w_last_pair = w_pair_acc && (r_cnt == r_nwords);
  assign w_zero_next = r_zero_acc && (w_s == '0);
  assign w_x_msb     = r_rev ? in_b[WIDTH-1] : in_a[WIDTH-1];
  assign w_y_msb     = r_rev ? in_a[WIDTH-1] : in_b[WIDTH-1];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_op          <= 1'b0;
      r_rev         <= 1'b0;
      r_nwords      <= '0;
      r_cnt         <= '0;
      r_carry       <= 1'b0;
      r_zero_acc    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_s       <= '0;
      r_out_last    <= 1'b0;
      r_flags_valid <= 1'b0;
      r_flags       <= '0;
      r_pend        <= '0;
    end else begin
      r_flags_valid <= 1'b0;
      if (abort && (r_state != ST_IDLE)) begin
        // Abort wins over any handshake in the same cycle.
        r_state     <= ST_IDLE;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (cmd_valid) begin
              r_state    <= ST_RUN;
              r_op       <= cmd_op;
              r_rev      <= cmd_rev;
              r_nwords   <= cmd_nwords;
              r_cnt      <= '0;
              r_zero_acc <= 1'b1;
              // Default carry equals op: 0 for add, 1 for x + ~y + 1.
              r_carry    <= cmd_use_c ? cmd_c : cmd_op;
            end
          end
          ST_RUN, ST_DRAIN: begin
            if (w_out_acc) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end
            if (w_pair_acc) begin
              r_out_valid <= 1'b1;
              r_out_s     <= w_s;
              r_out_last  <= w_last_pair;
              r_carry     <= w_c_out;
              r_zero_acc  <= w_zero_next;
              if (w_last_pair) begin
                r_state  <= ST_DRAIN;
                r_pend.n <= w_s[WIDTH-1];
                r_pend.z <= w_zero_next;
                r_pend.c <= w_c_out;
                r_pend.v <= calc_v(r_op, w_x_msb, w_y_msb, w_s[WIDTH-1]);
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            // In DRAIN the output slot can only hold the final word.
            if ((r_state == ST_DRAIN) && w_out_acc) begin
              r_state       <= ST_IDLE;
              r_flags       <= r_pend;
              r_flags_valid <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_s       = r_out_s;
  assign out_last    = r_out_last;
  assign flags_valid = r_flags_valid;
  assign flag_n      = r_flags.n;
  assign flag_z      = r_flags.z;
  assign flag_c      = r_flags.c;
  assign flag_v      = r_flags.v;

endmodule

// File: tb/tb_addsub_mp_sequencer.sv
// Directed testbench for addsub_mp_sequencer.
module tb_addsub_mp_sequencer;
  import addsub_pkg::*;

  localparam int W  = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_op = 1'b0;
  logic          cmd_rev = 1'b0;
  logic          cmd_use_c = 1'b0;
  logic          cmd_c = 1'b0;
  logic [CW-1:0] cmd_nwords = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          abort = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_s;
  logic          out_last;
  logic          flags_valid;
  logic          flag_n, flag_z, flag_c, flag_v;
  logic          busy;

  int total = 0;
  int bad = 0;
  int fv_cnt = 0;

  logic [W-1:0] va [8];
  logic [W-1:0] vb [8];
  logic [W-1:0] ve [8];

  addsub_mp_sequencer #(.WIDTH(W), .MAX_WORDS(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rev(cmd_rev), .cmd_use_c(cmd_use_c), .cmd_c(cmd_c),
    .cmd_nwords(cmd_nwords),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_last(out_last),
    .flags_valid(flags_valid), .flag_n(flag_n), .flag_z(flag_z),
    .flag_c(flag_c), .flag_v(flag_v), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (flags_valid) fv_cnt <= fv_cnt + 1;

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] nzcv();
    return {flag_n, flag_z, flag_c, flag_v};
  endfunction

  // Offers a command at a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input logic op, input logic rev, input logic use_c,
                          input logic c, input logic [CW-1:0] nw);
    @(negedge clk);
    check("cmd_ready_idle", {31'b0, cmd_ready}, 1);
    cmd_op = op; cmd_rev = rev; cmd_use_c = use_c; cmd_c = c;
    cmd_nwords = nw; cmd_valid = 1'b1;
    in_valid = 1'b1; in_a = va[0]; in_b = vb[0];
    #1;
    check("in_ready_idle", {31'b0, in_ready}, 0);
    @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b0;
    check("busy_run", {31'b0, busy}, 1);
  endtask

  // Streams n pairs and checks every result word, then the flag pulse.
  task automatic run_words(input string tag, input int n, input bit stall,
                           input logic [3:0] exp_nzcv);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int fv0 = fv_cnt;
    bit prev_stall = 1'b0;
    logic [W-1:0] prev_s = '0;
    while (got < n && cyc < 100) begin
      out_ready = stall ? ((cyc % 2) == 0) : 1'b1;
      in_valid  = (sent < n);
      in_a      = va[sent % 8];
      in_b      = vb[sent % 8];
      #1;
      if (out_valid) begin
        check($sformatf("%s_w%0d", tag, got), out_s, ve[got]);
        check($sformatf("%s_last%0d", tag, got), {31'b0, out_last},
              {31'b0, (got == n - 1)});
        if (prev_stall) check($sformatf("%s_hold%0d", tag, got), out_s, prev_s);
        if (!out_ready) check($sformatf("%s_inrdy_stall", tag),
                              {31'b0, in_ready}, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_s     = out_s;
      if (out_valid && out_ready) got++;
      if (in_valid && in_ready) sent++;
      cyc++;
      @(negedge clk);
    end
    if (got < n) check($sformatf("%s_timeout_words", tag), got, n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check($sformatf("%s_fvalid", tag), {31'b0, flags_valid}, 1);
    check($sformatf("%s_nzcv", tag), {28'b0, nzcv()}, {28'b0, exp_nzcv});
    check($sformatf("%s_idle", tag), {31'b0, cmd_ready}, 1);
    @(negedge clk);
    check($sformatf("%s_fpulse", tag), {31'b0, flags_valid}, 0);
    check($sformatf("%s_fcount", tag), fv_cnt - fv0, 1);
    check($sformatf("%s_nzcv_hold", tag), {28'b0, nzcv()}, {28'b0, exp_nzcv});
  endtask

  task automatic one_word(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e);
    va[0] = a; vb[0] = b; ve[0] = e;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    check("rst_outs", {26'b0, out_valid, out_last, flags_valid, busy,
                       in_ready, |nzcv()}, 0);
    check("rst_out_s", out_s, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single-word add
    one_word(32'd82347156, 32'd9483, 32'd82356639);
    send_cmd(OP_ADD, 1'b0, 1'b0, 1'b0, 3'd0);
    run_words("add1", 1, 1'b0, 4'b0000);

    // 2: single-word subtract, then reverse subtract
    one_word(32'd82347156, 32'd9483, 32'd82337673);
    send_cmd(OP_SUB, 1'b0, 1'b0, 1'b0, 3'd0);
    run_words("sub1", 1, 1'b0, 4'b0010);
    one_word(32'd82347156, 32'd9483, 32'hFB17A077);
    send_cmd(OP_SUB, 1'b1, 1'b0, 1'b0, 3'd0);
    run_words("rsb1", 1, 1'b0, 4'b1000);

    // 3: external carry-in
    one_word(32'd82347156, 32'd9483, 32'd82356640);
    send_cmd(OP_ADD, 1'b0, 1'b1, 1'b1, 3'd0);
    run_words("adc1", 1, 1'b0, 4'b0000);
    one_word(32'd82347156, 32'd9483, 32'd82337672);
    send_cmd(OP_SUB, 1'b0, 1'b1, 1'b0, 3'd0);
    run_words("sbc1", 1, 1'b0, 4'b0010);

    // Zero result: Z and C (no borrow) both set
    one_word(32'd5, 32'd5, 32'd0);
    send_cmd(OP_SUB, 1'b0, 1'b0, 1'b0, 3'd0);
    run_words("subz", 1, 1'b0, 4'b0110);

    // 4: carry and borrow chaining across two words
    va[0] = 32'hFFFFFFFF; va[1] = 32'h0; vb[0] = 32'h1; vb[1] = 32'h0;
    ve[0] = 32'h00000000; ve[1] = 32'h00000001;
    send_cmd(OP_ADD, 1'b0, 1'b0, 1'b0, 3'd1);
    run_words("add2", 2, 1'b0, 4'b0000);
    va[0] = 32'h0; va[1] = 32'h0; vb[0] = 32'h1; vb[1] = 32'h0;
    ve[0] = 32'hFFFFFFFF; ve[1] = 32'hFFFFFFFF;
    send_cmd(OP_SUB, 1'b0, 1'b0, 1'b0, 3'd1);
    run_words("sub2", 2, 1'b0, 4'b1000);

    // 5: eight words with a toggling out_ready; MS word overflows
    for (int i = 0; i < 7; i++) begin
      va[i] = i + 1;
      vb[i] = 32'h10 * i;
      ve[i] = (i + 1) + 32'h10 * i;
    end
    va[7] = 32'h7FFFFFFF; vb[7] = 32'h1; ve[7] = 32'h80000000;
    send_cmd(OP_ADD, 1'b0, 1'b0, 1'b0, 3'd7);
    run_words("add8", 8, 1'b1, 4'b1001);

    // 6: abort after two of four words, simultaneous with a third pair
    begin
      int fv0;
      fv0 = fv_cnt;
      va[0] = 32'd1; va[1] = 32'd2; va[2] = 32'd3; va[3] = 32'd4;
      vb[0] = 32'd0; vb[1] = 32'd0; vb[2] = 32'd0; vb[3] = 32'd0;
      send_cmd(OP_ADD, 1'b0, 1'b0, 1'b0, 3'd3);
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = va[0]; in_b = vb[0];
      @(negedge clk);
      check("abort_w0", out_s, 32'd1);
      in_a = va[1];
      @(negedge clk);
      check("abort_w1", out_s, 32'd2);
      in_a = va[2];
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; in_valid = 1'b0;
      check("abort_out_valid", {31'b0, out_valid}, 0);
      check("abort_idle", {30'b0, cmd_ready, busy}, 32'b10);
      check("abort_nzcv", {28'b0, nzcv()}, 32'b1001);
      @(negedge clk);
      check("abort_no_fvalid", fv_cnt - fv0, 0);
    end
    one_word(32'd82347156, 32'd9483, 32'd82356639);
    send_cmd(OP_ADD, 1'b0, 1'b0, 1'b0, 3'd0);
    run_words("post_abort", 1, 1'b0, 4'b0000);

    // Asynchronous reset in the middle of RUN
    va[0] = 32'd7; vb[0] = 32'd8;
    send_cmd(OP_ADD, 1'b0, 1'b0, 1'b0, 3'd1);
    in_valid = 1'b1; in_a = 32'd7; in_b = 32'd8;
    @(negedge clk);
    check("pre_rst_out", out_s, 32'd15);
    rst = 1'b1;
    #1;
    check("mid_rst_outs", {26'b0, out_valid, out_last, flags_valid, busy,
                           in_ready, |nzcv()}, 0);
    check("mid_rst_out_s", out_s, 0);
    check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 1);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;

    one_word(32'd5, 32'd5, 32'd0);
    send_cmd(OP_SUB, 1'b0, 1'b0, 1'b0, 3'd0);
    run_words("post_rst", 1, 1'b0, 4'b0110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: observed=no_finish expected=finish");
    $fatal(1, "time limit reached");
  end

endmodule
